// File: rtl/ahb_lite_master_port.sv
// Single-initiator AHB-Lite master: turns a valid/ready command stream into pipelined SINGLE
// transfers and returns one in-order response per command.
module ahb_lite_master_port #(
  parameter bit ADDR_CHECK = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  logic        ap_valid_q, ap_valid_d;
  logic [31:0] ap_wdata_q;
  logic        dp_valid_q, dp_valid_d;
  logic        dp_write_q;
  logic [1:0]  dp_addr_q;
  logic [2:0]  dp_size_q;
  logic        err_pend_q;
  logic        rej_pend_q, rej_pend_d;

  logic cmd_bad, cmd_accept, ap_hold, ap_adv, dp_done, rej_emit;

  function automatic logic [31:0] lane_replicate(input logic [2:0] size, input logic [31:0] data);
    logic [31:0] r;
    case (size)
      3'd0:    r = {4{data[7:0]}};
      3'd1:    r = {2{data[15:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] read_extract(input logic [2:0] size, input logic [1:0] addr,
                                               input logic [31:0] data);
    logic [31:0] r;
    case (size)
      3'd0:    r = {24'd0, data[{addr, 3'b000} +: 8]};
      3'd1:    r = {16'd0, (addr[1] ? data[31:16] : data[15:0])};
      default: r = data;
    endcase
    return r;
  endfunction

  always_comb begin
    cmd_bad    = 1'b0;
    cmd_ready  = 1'b0;
    cmd_accept = 1'b0;
    ap_hold    = 1'b0;
    ap_adv     = 1'b0;
    dp_done    = 1'b0;
    ap_valid_d = 1'b0;
    dp_valid_d = 1'b0;
    rej_emit   = 1'b0;
    rej_pend_d = 1'b0;
    HTRANS     = HtransIdle;

    if (ADDR_CHECK) begin
      cmd_bad = (cmd_size > 3'd2) || ((cmd_size == 3'd1) && cmd_addr[0]) ||
                ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00));
    end
    cmd_ready  = HRESETn & ~rej_pend_q & (~ap_valid_q | (HREADY & ~HRESP));
    cmd_accept = cmd_valid & cmd_ready;

    // Both cycles of an ERROR response cancel the address phase; a single-cycle ERROR does not.
    ap_hold = dp_valid_q & HRESP & (~HREADY | err_pend_q);
    ap_adv  = ap_valid_q & HREADY & ~ap_hold;
    dp_done = dp_valid_q & HREADY;

    ap_valid_d = (cmd_accept & ~cmd_bad) | (ap_valid_q & ~ap_adv);
    dp_valid_d = ap_adv | (dp_valid_q & ~dp_done);

    // A reject answers only once every older transfer has answered, keeping command order.
    rej_emit   = (rej_pend_q | (cmd_accept & cmd_bad)) & ~dp_done & ~ap_valid_d & ~dp_valid_d;
    rej_pend_d = (rej_pend_q | (cmd_accept & cmd_bad)) & ~rej_emit;

    HTRANS = (ap_valid_q & ~ap_hold) ? HtransNonseq : HtransIdle;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ap_valid_q <= 1'b0;
      ap_wdata_q <= 32'd0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= 2'd0;
      dp_size_q  <= 3'd0;
      err_pend_q <= 1'b0;
      rej_pend_q <= 1'b0;
      HADDR      <= 32'd0;
      HWRITE     <= 1'b0;
      HSIZE      <= 3'd0;
      HWDATA     <= 32'd0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= 32'd0;
    end else begin
      ap_valid_q <= ap_valid_d;
      dp_valid_q <= dp_valid_d;
      rej_pend_q <= rej_pend_d;
      err_pend_q <= HREADY ? 1'b0 : (err_pend_q | (dp_valid_q & HRESP));
      if (cmd_accept && !cmd_bad) begin
        HADDR      <= cmd_addr;
        HWRITE     <= cmd_write;
        HSIZE      <= cmd_size;
        ap_wdata_q <= lane_replicate(cmd_size, cmd_wdata);
      end
      if (ap_adv) begin
        dp_write_q <= HWRITE;
        dp_addr_q  <= HADDR[1:0];
        dp_size_q  <= HSIZE;
        HWDATA     <= ap_wdata_q;
      end
      rsp_valid <= dp_done | rej_emit;
      rsp_err   <= dp_done ? HRESP : rej_emit;
      rsp_rdata <= (dp_done && !dp_write_q && !HRESP) ?
                   read_extract(dp_size_q, dp_addr_q, HRDATA) : 32'd0;
    end
  end

  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_master_port.sv
// Bench for ahb_lite_master_port: directed scenarios plus random traffic against a byte-array
// memory model, with a bus slave that inserts random wait states and ERROR responses.
module tb_ahb_lite_master_port;

  logic        HCLK, HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  ahb_lite_master_port #(.ADDR_CHECK(1'b1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] wr_q[$];
  int          force_q[$];
  logic [7:0]  model_mem[64];
  logic [31:0] slave_mem[16];
  int n_checks = 0, n_fail = 0, cyc = 0, rsp_count = 0, rand_max = 0;
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end
  initial forever begin
    @(posedge HCLK);
    cyc++;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  // Expected response per accepted command, from address/size rules and the byte model.
  task automatic model_accept(input logic w, input logic [31:0] a, input logic [2:0] sz,
                              input logic [31:0] wd, input int lat);
    exp_t        e;
    logic [31:0] lanes, rd;
    int          n;
    e.acc = cyc; e.lat = lat; e.err = 1'b0; e.rdata = 32'd0;
    n = 1 << sz;
    if (sz > 3'd2 || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00)) begin
      e.err = 1'b1;
    end else begin
      if (w) begin
        for (int i = 0; i < 4; i++) lanes[8*i +: 8] = wd[8*(i % n) +: 8];
        wr_q.push_back(lanes);
      end
      if (a[31:28] == 4'hE) e.err = 1'b1;
      else if (w) begin
        for (int k = 0; k < n; k++) model_mem[(int'(a[5:0]) + k) % 64] = wd[8*k +: 8];
      end else begin
        rd = 32'd0;
        for (int k = 0; k < n; k++) rd[8*k +: 8] = model_mem[(int'(a[5:0]) + k) % 64];
        e.rdata = rd;
      end
    end
    exp_q.push_back(e);
  endtask

  // Called at posedge+2; returns at posedge+2 of the cycle after acceptance.
  task automatic send(input logic w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input int lat);
    bit acc = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge HCLK);
      if (cmd_ready) acc = 1;
    end
    if (!acc) check("cmd_timeout", {31'd0, cmd_ready}, 32'd1);
    else model_accept(w, a, sz, wd, lat);
    @(posedge HCLK);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #2;
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && exp_q.size() > 0; t++) @(negedge HCLK);
    check("drain_empty", exp_q.size(), 32'd0);
    @(posedge HCLK);
    #2;
  endtask

  // Response monitor
  initial forever begin
    @(negedge HCLK);
    if (rsp_valid === 1'b1) begin
      rsp_count++;
      last_rdata = rsp_rdata;
      if (exp_q.size() == 0) check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        if (mon_e.lat > 0) check("rsp_latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  // Bus protocol monitor
  initial begin
    logic [31:0] p_haddr;
    logic [1:0]  p_htrans;
    logic [2:0]  p_hsize;
    logic        p_hwrite, p_hready, p_hresp, p_ok;
    p_ok = 1'b0;
    forever begin
      @(negedge HCLK);
      if (HRESETn && p_ok) begin
        check("htrans_legal", {31'd0, HTRANS[0]}, 32'd0);
        if (HRESP) check("err_cancel", {30'd0, HTRANS}, 32'd0);
        if (p_htrans == 2'b10 && !p_hready && !p_hresp) begin
          check("ap_stable_addr", HADDR, p_haddr);
          check("ap_stable_ctl", {28'd0, HWRITE, HSIZE}, {28'd0, p_hwrite, p_hsize});
        end
        if (HTRANS == 2'b10 && !HREADY) check("ready_in_wait", {31'd0, cmd_ready}, 32'd0);
      end
      p_haddr = HADDR; p_htrans = HTRANS; p_hsize = HSIZE; p_hwrite = HWRITE;
      p_hready = HREADY; p_hresp = HRESP; p_ok = HRESETn;
    end
  end

  // AHB-Lite slave: addresses with [31:28] = 0xE answer ERROR, others hit a 64-byte memory.
  initial begin
    logic [31:0] s_haddr, s_hwdata, sl_addr;
    logic [1:0]  s_htrans;
    logic [2:0]  s_hsize, sl_size;
    logic        s_hwrite, s_hready, sl_active, sl_write, sl_err, err_ph;
    int          waits;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'd0;
    sl_active = 1'b0; err_ph = 1'b0; waits = 0;
    forever begin
      @(negedge HCLK);
      s_haddr = HADDR; s_htrans = HTRANS; s_hsize = HSIZE; s_hwrite = HWRITE;
      s_hwdata = HWDATA; s_hready = HREADY;
      @(posedge HCLK);
      #1;
      if (!HRESETn) begin
        sl_active = 1'b0; err_ph = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
      end else begin
        if (s_hready && sl_active) begin
          if (sl_write) begin
            if (wr_q.size() == 0) check("wr_expected", wr_q.size(), 32'd1);
            else check("hwdata_lanes", s_hwdata, wr_q.pop_front());
            if (!sl_err)
              for (int j = 0; j < 4; j++)
                if ((j >> sl_size) == (int'(sl_addr[1:0]) >> sl_size))
                  slave_mem[sl_addr[5:2]][8*j +: 8] = s_hwdata[8*j +: 8];
          end
          sl_active = 1'b0;
        end
        if (s_hready && s_htrans == 2'b10) begin
          sl_active = 1'b1; sl_addr = s_haddr; sl_write = s_hwrite; sl_size = s_hsize;
          sl_err = (s_haddr[31:28] == 4'hE); err_ph = 1'b0;
          waits = (force_q.size() > 0) ? force_q.pop_front() : $urandom_range(rand_max, 0);
        end
        HRDATA = $urandom;
        if (!sl_active) begin
          HREADY = 1'b1; HRESP = 1'b0;
        end else if (waits > 0) begin
          HREADY = 1'b0; HRESP = 1'b0; waits--;
        end else if (sl_err) begin
          HREADY = err_ph; HRESP = 1'b1; err_ph = 1'b1;
        end else begin
          HREADY = 1'b1; HRESP = 1'b0;
          if (!sl_write) HRDATA = slave_mem[sl_addr[5:2]];
        end
      end
    end
  end

  initial begin
    logic [31:0] a, wd;
    logic [5:0]  a6;
    logic [2:0]  sz;
    int          r, cnt;
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 32'd0; cmd_size = 3'd0; cmd_wdata = 32'd0;
    for (int i = 0; i < 64; i++) begin
      model_mem[i] = 8'(i * 37 + 5);
      slave_mem[i / 4][8*(i % 4) +: 8] = 8'(i * 37 + 5);
    end

    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_htrans", {30'd0, HTRANS}, 32'd0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_ctl", {27'd0, HWRITE, HSIZE, cmd_ready}, 32'd0);
    check("rst_rsp", {31'd0, rsp_valid | rsp_err}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("const_sig", {24'd0, HBURST, HPROT, HMASTLOCK}, {24'd0, 3'b000, 4'b0011, 1'b0});
    @(posedge HCLK);
    #2;
    HRESETn = 1'b1;
    idle(1);

    // Zero-wait word write then read
    send(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 3);
    @(negedge HCLK);
    @(negedge HCLK);
    check("wr_hwdata", HWDATA, 32'hDEAD_BEEF);
    @(posedge HCLK);
    #2;
    send(1'b0, 32'h10, 3'd2, 32'd0, 3);
    drain();
    check("rd_deadbeef", last_rdata, 32'hDEAD_BEEF);

    // Four pipelined word writes
    cnt = rsp_count;
    for (int i = 0; i < 4; i++) send(1'b1, 32'h30 + 32'(4 * i), 3'd2, $urandom, 3);
    drain();
    check("pipe_rsp_count", rsp_count - cnt, 32'd4);

    // Byte write lanes, halfword read extraction
    send(1'b1, 32'h13, 3'd0, 32'h0000_00A5, 3);
    @(negedge HCLK);
    check("byte_ap", {HADDR[7:0], 5'd0, HSIZE, 14'd0, HTRANS}, {8'h13, 8'h00, 14'd0, 2'b10});
    @(negedge HCLK);
    check("byte_hwdata", HWDATA, 32'hA5A5_A5A5);
    @(posedge HCLK);
    #2;
    drain();
    send(1'b1, 32'h20, 3'd2, 32'h1234_5678, 3);
    send(1'b0, 32'h22, 3'd1, 32'd0, 3);
    drain();
    check("hw_rdata", last_rdata, 32'h0000_1234);

    // Three wait states on a read while a write waits in address phase
    force_q.push_back(3);
    send(1'b0, 32'h20, 3'd2, 32'd0, 6);
    send(1'b1, 32'h24, 3'd2, $urandom, 6);
    drain();

    // ERROR on A while B is in address phase
    send(1'b0, 32'hE000_0040, 3'd2, 32'd0, 4);
    send(1'b0, 32'h20, 3'd2, 32'd0, 5);
    @(negedge HCLK);
    check("err_c1_htrans", {30'd0, HTRANS, 1'b0, HRESP}, {30'd0, 2'b00, 1'b0, 1'b1});
    @(negedge HCLK);
    @(negedge HCLK);
    check("redrive_htrans", {30'd0, HTRANS}, {30'd0, 2'b10});
    check("redrive_haddr", HADDR, 32'h20);
    @(posedge HCLK);
    #2;
    drain();
    check("err_b_rdata", last_rdata, 32'h1234_5678);

    // Local reject
    send(1'b1, 32'h02, 3'd2, 32'h1111_1111, 1);
    @(negedge HCLK);
    check("rej_htrans", {30'd0, HTRANS}, 32'd0);
    check("rej_rsp", {30'd0, rsp_valid, rsp_err}, 32'd3);
    @(posedge HCLK);
    #2;
    drain();

    // Reset while a read sits in data phase
    force_q.push_back(3);
    send(1'b0, 32'h04, 3'd2, 32'd0, 0);
    @(posedge HCLK);
    #2;
    HRESETn = 1'b0;
    exp_q.delete();
    wr_q.delete();
    cnt = rsp_count;
    @(negedge HCLK);
    @(negedge HCLK);
    check("rst_mid_htrans", {30'd0, HTRANS}, 32'd0);
    check("rst_mid_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge HCLK);
    #2;
    HRESETn = 1'b1;
    repeat (6) @(negedge HCLK);
    check("rst_no_rsp", rsp_count - cnt, 32'd0);
    @(posedge HCLK);
    #2;

    // Random traffic with wait states, ERRORs and rejects
    rand_max = 2;
    for (int i = 0; i < 250; i++) begin
      r  = $urandom_range(99, 0);
      sz = 3'($urandom_range(2, 0));
      a6 = 6'($urandom_range(63, 0));
      if (r >= 8) a6 = (a6 >> sz) << sz;
      if (r >= 8 && r < 11) sz = 3'd3;
      a  = {26'd0, a6};
      if (r >= 11 && r < 21) a = 32'hE000_0000 | a;
      wd = $urandom;
      send(1'($urandom_range(1, 0)), a, sz, wd, 0);
      if ($urandom_range(1, 0) == 0) idle($urandom_range(2, 0));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
